// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_scheduler_if
// Brief  : Requester, transmitter and completion signals of the TX scheduler.
// Rev    : 1.0  initial release
// ============================================================================
interface uart_tx_scheduler_if #(
  parameter int DATA_WIDTH = 8
);
  logic                      rf_rd_vld;
  logic [DATA_WIDTH-1:0]     rf_rd_data;
  logic                      rf_rdy;
  logic                      alu_out_vld;
  logic [2*DATA_WIDTH-1:0]   alu_out;
  logic                      alu_rdy;
  logic                      tx_busy;
  logic [DATA_WIDTH-1:0]     tx_p_data;
  logic                      tx_d_vld;
  logic                      frame_done;

  modport slave (
    input  rf_rd_vld, rf_rd_data, alu_out_vld, alu_out, tx_busy,
    output rf_rdy, alu_rdy, tx_p_data, tx_d_vld, frame_done
  );

  modport master (
    output rf_rd_vld, rf_rd_data, alu_out_vld, alu_out, tx_busy,
    input  rf_rdy, alu_rdy, tx_p_data, tx_d_vld, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_scheduler
// Brief  : Shares one UART transmitter between an RF byte slot and an ALU
//          16-bit slot. Define UART_TX_SCHED_RR_EN for round-robin arbitration.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_scheduler #(
  parameter int DATA_WIDTH = 8
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  uart_tx_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACC  = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                  state;
  logic                    rf_full;
  logic                    alu_full;
  logic [DATA_WIDTH-1:0]   rf_data;
  logic [2*DATA_WIDTH-1:0] alu_data;
  logic                    grant_alu;
  logic                    byte_sel;
  logic [DATA_WIDTH-1:0]   tx_data;
  logic                    tx_vld;
  logic                    done_pulse;
  logic                    pick_alu;
  logic                    frame_end;

  // pick_alu is only consulted in IDLE when at least one slot is full
`ifdef UART_TX_SCHED_RR_EN
  logic last_alu;
  always_comb pick_alu = alu_full && (!rf_full || !last_alu);
`else
  always_comb pick_alu = !rf_full;
`endif

  always_comb frame_end = (state == WAIT_DONE) && !bus.tx_busy && (!grant_alu || byte_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_full  <= 1'b0;
      alu_full <= 1'b0;
      rf_data  <= '0;
      alu_data <= '0;
    end else begin
      if (frame_end && !grant_alu) begin
        rf_full <= 1'b0;
      end else if (bus.rf_rd_vld && !rf_full) begin
        rf_full <= 1'b1;
        rf_data <= bus.rf_rd_data;
      end
      if (frame_end && grant_alu) begin
        alu_full <= 1'b0;
      end else if (bus.alu_out_vld && !alu_full) begin
        alu_full <= 1'b1;
        alu_data <= bus.alu_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_alu  <= 1'b0;
      byte_sel   <= 1'b0;
      tx_data    <= '0;
      tx_vld     <= 1'b0;
      done_pulse <= 1'b0;
`ifdef UART_TX_SCHED_RR_EN
      last_alu   <= 1'b1;
`endif
    end else begin
      done_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (rf_full || alu_full) begin
            grant_alu <= pick_alu;
            byte_sel  <= 1'b0;
            tx_data   <= pick_alu ? alu_data[DATA_WIDTH-1:0] : rf_data;
            tx_vld    <= 1'b1;
            state     <= WAIT_ACC;
`ifdef UART_TX_SCHED_RR_EN
            last_alu  <= pick_alu;
`endif
          end
        end
        WAIT_ACC: begin
          if (bus.tx_busy) begin
            tx_vld <= 1'b0;
            state  <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (grant_alu && !byte_sel) begin
              byte_sel <= 1'b1;
              tx_data  <= alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
              tx_vld   <= 1'b1;
              state    <= WAIT_ACC;
            end else begin
              done_pulse <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rf_rdy     = !rf_full;
  assign bus.alu_rdy    = !alu_full;
  assign bus.tx_p_data  = tx_data;
  assign bus.tx_d_vld   = tx_vld;
  assign bus.frame_done = done_pulse;

endmodule
`default_nettype wire
